// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start/data/parity/stop framing
// and ack sampling, all clocked off a glitch-filtered copy of the device clock.
module ps2_tx #(
    parameter int RTS_CYCLES = 5000,
    parameter int FILT_LEN   = 8
) (
    input  logic       clk_ps2_tx,
    input  logic       reset_ps2_tx,
    input  logic       wr_ps2_tx,
    input  logic [7:0] din_ps2_tx,
    input  logic       ps2c_in_ps2_tx,
    input  logic       ps2d_in_ps2_tx,
    output logic       ps2c_oe_ps2_tx,
    output logic       ps2d_oe_ps2_tx,
    output logic       tx_idle_ps2_tx,
    output logic       tx_done_tick_ps2_tx,
    output logic       tx_ack_err_ps2_tx
);
    localparam int RW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RTS, S_START, S_DATA, S_STOP} state_t;

    state_t              r_state;
    logic [FILT_LEN-1:0] r_filt;
    logic                r_fc;
    logic                r_fall;
    logic [RW-1:0]       r_rts_cnt;
    logic [3:0]          r_bit_cnt;
    logic [8:0]          r_shift;
    logic                r_c_oe;
    logic                r_d_oe;
    logic                r_done;
    logic                r_ack_err;
    logic                w_all0;
    logic                w_all1;

    assign w_all0 = (r_filt == '0);
    assign w_all1 = (r_filt == '1);

    // Filtered level only moves once the whole window agrees; the tick marks 1->0.
    always_ff @(posedge clk_ps2_tx) begin
        if (reset_ps2_tx) begin
            r_filt <= '1;
            r_fc   <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_filt <= {ps2c_in_ps2_tx, r_filt[FILT_LEN-1:1]};
            r_fall <= 1'b0;
            if (w_all1) begin
                r_fc <= 1'b1;
            end else if (w_all0) begin
                r_fc   <= 1'b0;
                r_fall <= r_fc;
            end
        end
    end

    always_ff @(posedge clk_ps2_tx) begin
        if (reset_ps2_tx) begin
            r_state   <= S_IDLE;
            r_rts_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_c_oe    <= 1'b0;
            r_d_oe    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_c_oe <= 1'b0;
                    r_d_oe <= 1'b0;
                    if (wr_ps2_tx) begin
                        r_shift   <= {~^din_ps2_tx, din_ps2_tx};
                        r_rts_cnt <= RW'(RTS_CYCLES - 1);
                        r_ack_err <= 1'b0;
                        r_c_oe    <= 1'b1;
                        r_state   <= S_RTS;
                    end
                end
                S_RTS: begin
                    if (r_rts_cnt == '0) begin
                        r_c_oe  <= 1'b0;
                        r_d_oe  <= 1'b1;
                        r_state <= S_START;
                    end else begin
                        r_rts_cnt <= r_rts_cnt - RW'(1);
                    end
                end
                S_START: begin
                    if (r_fall) begin
                        r_bit_cnt <= 4'd8;
                        r_d_oe    <= ~r_shift[0];
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    // Line always shows shift[0]; advance it on each device clock fall.
                    if (r_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            r_d_oe  <= 1'b0;
                            r_state <= S_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[8:1]};
                            r_bit_cnt <= r_bit_cnt - 4'd1;
                            r_d_oe    <= ~r_shift[1];
                        end
                    end
                end
                S_STOP: begin
                    if (r_fall) begin
                        r_done    <= 1'b1;
                        r_ack_err <= ps2d_in_ps2_tx;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ps2c_oe_ps2_tx      = r_c_oe;
    assign ps2d_oe_ps2_tx      = r_d_oe;
    assign tx_idle_ps2_tx      = (r_state == S_IDLE);
    assign tx_done_tick_ps2_tx = r_done;
    assign tx_ack_err_ps2_tx   = r_ack_err;
endmodule
